// File: rtl/sram22_req_ctrl_if.sv
// sram22_req_ctrl_if: request/response handshake bundle between a bus adapter and sram22_req_ctrl.
interface sram22_req_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WMASK_WIDTH = 4
) ();
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram22_req_ctrl.sv
// sram22_req_ctrl: request controller for a 1-cycle-latency sram22 macro with a credit-checked response FIFO.
// Optional power-up zero fill of the macro is enabled by defining SRAM22_CTRL_INIT_EN.
module sram22_req_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WMASK_WIDTH = 4,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram22_req_ctrl_if.slave       bus,
    output logic                   init_done,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic                  run;
    logic                  fire;
    logic                  pop;
    logic                  rd_pend;
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [CW-1:0]         count;
    logic [CW:0]           credit;
    logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
    logic [ADDR_WIDTH-1:0] init_addr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

`ifdef SRAM22_CTRL_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] init_addr_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state     <= state_nx;
            init_addr <= init_addr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        init_addr_nx = init_addr;
        if (state == INIT) begin
            init_addr_nx = init_addr + 1'b1;
            state_nx     = &init_addr ? RUN : INIT;
        end
    end

    assign run       = state == RUN;
    assign init_done = run;
`else
    assign run       = 1'b1;
    assign init_done = 1'b1;
    assign init_addr = '0;
`endif

    // Credit counts both stored responses and the read whose data lands next edge.
    assign bus.rsp_valid = count != '0;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign credit        = {1'b0, count} + (CW+1)'(rd_pend) - (CW+1)'(pop);
    assign bus.req_ready = run && (credit < (CW+1)'(RSP_DEPTH));
    assign fire          = bus.req_valid && bus.req_ready;
    assign bus.rsp_rdata = bus.rsp_valid ? fifo[rp] : '0;

    assign sram_we    = run ? fire && bus.req_we : 1'b1;
    assign sram_wmask = run ? (fire && bus.req_we ? bus.req_wmask : '0) : '1;
    assign sram_addr  = run ? bus.req_addr : init_addr;
    assign sram_din   = run ? bus.req_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
        end else begin
            rd_pend <= fire && !bus.req_we;
            wp      <= rd_pend ? nxt(wp) : wp;
            rp      <= pop ? nxt(rp) : rp;
            count   <= count + CW'(rd_pend) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pend) fifo[wp] <= sram_dout;
    end
endmodule

// File: tb/tb_sram22_req_ctrl.sv
// tb_sram22_req_ctrl: randomized scoreboard bench for sram22_req_ctrl with a behavioural macro and reference memory.
// Covers the zero-fill sequence too when SRAM22_CTRL_INIT_EN is defined.
module tb_sram22_req_ctrl;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MW = 4;
    localparam int D  = 2;
    localparam int N  = 2 ** AW;

    typedef struct {
        logic [DW-1:0] d;
        bit            k;
        int            e;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    logic [DW-1:0] smem [N];
    logic [DW-1:0] rmem [N];
    bit            rknown [N];
    ent_t          q [$];
    int            sr;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    sram22_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

    sram22_req_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .RSP_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .init_done(init_done),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Behavioural macro: byte-masked write, registered read when not writing.
    always @(posedge clk) begin
        if (sram_we) begin
            for (int i = 0; i < MW; i++)
                if (sram_wmask[i]) smem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
        end else begin
            sram_dout <= smem[sram_addr];
        end
    end

    task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model and monitor: a read's data is due two edges after it is accepted.
    always @(negedge clk) begin
        bit exp_done, ev, pop, er, fire;
        if (rst) begin
            q.delete();
            sr = 0;
            chk("rsp_valid_in_reset", {31'b0, bus.rsp_valid}, 32'd0);
`ifdef SRAM22_CTRL_INIT_EN
            for (int a = 0; a < N; a++) begin
                rmem[a]   = '0;
                rknown[a] = 1'b1;
            end
`endif
        end else begin
`ifdef SRAM22_CTRL_INIT_EN
            exp_done = sr >= N;
`else
            exp_done = 1'b1;
`endif
            chk("init_done", {31'b0, init_done}, {31'b0, exp_done});
            ev = q.size() > 0 && sr >= q[0].e + 1;
            chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, ev});
            if (ev && q[0].k) chk("rsp_rdata", bus.rsp_rdata, q[0].d);
            pop = ev && bus.rsp_ready;
            er  = exp_done && (q.size() - int'(pop) < D);
            chk("req_ready", {31'b0, bus.req_ready}, {31'b0, er});
            fire = bus.req_valid && er;
            if (!exp_done) begin
                chk("init_we", {31'b0, sram_we}, 32'd1);
                chk("init_addr", {20'b0, sram_addr}, {20'b0, sr[AW-1:0]});
            end else begin
                chk("sram_we", {31'b0, sram_we}, {31'b0, fire && bus.req_we});
                chk("sram_wmask", {28'b0, sram_wmask}, {28'b0, (fire && bus.req_we) ? bus.req_wmask : 4'h0});
                if (fire) chk("sram_addr", {20'b0, sram_addr}, {20'b0, bus.req_addr});
                if (fire && bus.req_we) chk("sram_din", sram_din, bus.req_wdata);
            end
            if (pop) void'(q.pop_front());
            if (fire) begin
                if (bus.req_we) begin
                    for (int i = 0; i < MW; i++)
                        if (bus.req_wmask[i]) rmem[bus.req_addr][8*i +: 8] = bus.req_wdata[8*i +: 8];
                    rknown[bus.req_addr] = rknown[bus.req_addr] || (&bus.req_wmask);
                end else begin
                    q.push_back('{d: rmem[bus.req_addr], k: rknown[bus.req_addr], e: sr + 1});
                end
            end
            sr++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit we, input logic [MW-1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit fired = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_wmask = m;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int t = 0; t < 200 && !fired; t++) begin
            @(negedge clk);
            fired = bus.req_ready;
            step();
        end
        if (!fired) begin
            $display("FAIL send_timeout: req_ready never rose for addr %h", a);
            $fatal(1, "request timeout");
        end
    endtask

    task automatic wait_init();
        int t = 0;
        while (!init_done && t < N + 100) begin
            step();
            t++;
        end
        if (!init_done) begin
            $display("FAIL init_timeout: init_done=%0d after %0d cycles", init_done, t);
            $fatal(1, "init timeout");
        end
    endtask

    task automatic drain();
        int t = 0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        while ((q.size() > 0 || bus.rsp_valid) && t < 100) begin
            step();
            t++;
        end
        if (q.size() > 0) begin
            $display("FAIL drain_timeout: %0d responses outstanding", q.size());
            $fatal(1, "drain timeout");
        end
        step();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wmask = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_init();

        // Full write then read-back.
        send(1'b1, 4'hF, 12'h005, 32'hDEADBEEF);
        send(1'b0, 4'h0, 12'h005, 32'h0);
        drain();

        // Partial-mask overwrite keeps unmasked lanes.
        send(1'b1, 4'hF, 12'h010, 32'h11223344);
        send(1'b1, 4'b0101, 12'h010, 32'hAABBCCDD);
        send(1'b0, 4'h0, 12'h010, 32'h0);
        drain();

        // Back-to-back reads with the consumer always ready.
        for (int a = 0; a < 16; a++) send(1'b1, 4'hF, 12'(a), $urandom);
        for (int a = 0; a < 16; a++) send(1'b0, 4'h0, 12'(a), 32'h0);
        drain();

        // Stall the consumer and keep offering reads.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = 12'(i);
            step();
        end
        bus.req_valid = 1'b0;
        repeat (3) step();
        drain();

        // Reset with one read in the FIFO and one on the macro.
        bus.rsp_ready = 1'b0;
        send(1'b0, 4'h0, 12'h003, 32'h0);
        send(1'b0, 4'h0, 12'h004, 32'h0);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        wait_init();
        bus.rsp_ready = 1'b1;
        repeat (5) step();

        // Random traffic over a small address window to force read-after-write hits.
        for (int c = 0; c < 800; c++) begin
            bus.req_valid = ($urandom % 4) != 0;
            bus.req_we    = $urandom % 2;
            bus.req_wmask = 4'($urandom);
            bus.req_addr  = 12'($urandom % 16);
            bus.req_wdata = $urandom;
            bus.rsp_ready = ($urandom % 3) != 0;
            step();
        end
        drain();

`ifdef SRAM22_CTRL_INIT_EN
        // Fill memory with ones, then reset: the zero fill must clear it.
        for (int a = 0; a < N; a++) send(1'b1, 4'hF, 12'(a), 32'hFFFFFFFF);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        wait_init();
        send(1'b0, 4'h0, 12'hABC, 32'h0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
